// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } rx_samp_state_e;

    // Prescale must exceed the sample count by this much so that the
    // window and the decision edge never overlap or wrap.
    localparam int unsigned MIN_PRESCALE_MARGIN = 4;

    // First sample edge: window centred on the middle of the bit.
    function automatic int unsigned sample_lo(input int unsigned prescale,
                                              input int unsigned n);
        return (prescale >> 1) - (n >> 1);
    endfunction

    // Last sample edge, inclusive.
    function automatic int unsigned sample_hi(input int unsigned prescale,
                                              input int unsigned n);
        return (prescale >> 1) + (n >> 1);
    endfunction

endpackage

// File: rtl/uart_rx_oversampler_sync.sv
// Two-flop synchronizer for the RX pin. Resets to 1 (idle line level).
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Double-register the asynchronous pin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART receive-bit sampler: majority vote over NUM_SAMPLES samples centred
// in the bit, with per-bit valid pulse, noise flag and config-error flag.
// Optional macro RX_SYNC_EN inserts a 2-flop synchronizer on rx_in.
module uart_rx_oversampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W  = 6,
    parameter int unsigned NUM_SAMPLES = 3,
    parameter int unsigned CNT_W       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  samp_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_err,
    output logic                  cfg_err
);

    localparam int unsigned HALF = NUM_SAMPLES >> 1;

    rx_samp_state_e        state_q, state_d;
    logic [CNT_W-1:0]      ones_q, ones_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  bit_q, bit_d;
    logic                  noise_q, noise_d;
    logic                  valid_q, valid_d;
    logic                  cfg_err_q;
    logic                  rx_s;
    logic [PRESCALE_W-1:0] win_lo, win_hi, dec_edge;
    logic                  in_win;

`ifdef RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_in),
        .q_o (rx_s)
    );
`else
    assign rx_s = rx_in;
`endif

    assign win_lo   = PRESCALE_W'(sample_lo(32'(prescale), NUM_SAMPLES));
    assign win_hi   = PRESCALE_W'(sample_hi(32'(prescale), NUM_SAMPLES));
    assign dec_edge = prescale - PRESCALE_W'(2);
    assign in_win   = (edge_cnt >= win_lo) && (edge_cnt <= win_hi);

    // State, counters, outputs and the registered config check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ones_q    <= '0;
            cnt_q     <= '0;
            bit_q     <= 1'b0;
            noise_q   <= 1'b0;
            valid_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            noise_q   <= noise_d;
            valid_q   <= valid_d;
            cfg_err_q <= (32'(prescale) < NUM_SAMPLES + MIN_PRESCALE_MARGIN);
        end
    end

    // Next-state: samp_en low forces IDLE from anywhere; a bad config
    // suppresses sampling, the valid pulse and any output change.
    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        noise_d = noise_q;
        valid_d = 1'b0;
        if (!samp_en || state_q == IDLE) begin
            ones_d  = '0;
            cnt_d   = '0;
            if (!cfg_err_q) begin
                bit_d   = 1'b0;
                noise_d = 1'b0;
            end
            state_d = samp_en ? COLLECT : IDLE;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (edge_cnt == dec_edge) begin
                        state_d = HOLD;
                        ones_d  = '0;
                        cnt_d   = '0;
                        if (!cfg_err_q) begin
                            // A short window (entered mid-bit) still uses the
                            // full-set threshold but is always flagged noisy.
                            bit_d   = (32'(ones_q) > HALF);
                            noise_d = (32'(cnt_q) < NUM_SAMPLES) ||
                                      ((ones_q != '0) && (32'(ones_q) != NUM_SAMPLES));
                            valid_d = 1'b1;
                        end
                    end else if (in_win && !cfg_err_q) begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        ones_d = ones_q + CNT_W'(rx_s);
                    end
                end
                HOLD: begin
                    ones_d = '0;
                    cnt_d  = '0;
                    if (edge_cnt == '0) state_d = COLLECT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign sampled_bit  = bit_q;
    assign sample_valid = valid_q;
    assign noise_err    = noise_q;
    assign cfg_err      = cfg_err_q;

endmodule
